// File: rtl/rmt_ingress_arbiter_pkg.sv
// Shared definitions for the RMT ingress arbiter: FSM state encoding, the
// stats counter width and a port-index width helper.
package rmt_ingress_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int STATS_CNT_W = 32;

    // Index width for a port vector; never narrower than one bit.
    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/rmt_ingress_arbiter_rr_select.sv
// Combinational round-robin picker: returns the first asserted valid bit at or
// after rr_ptr, wrapping modulo NUM_PORTS, plus an any-valid flag.
module rmt_ingress_arbiter_rr_select
    import rmt_ingress_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PW        = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [PW-1:0]        rr_ptr,
    output logic [PW-1:0]        winner,
    output logic                 any_valid
);

    localparam logic [PW:0] NP_W = (PW+1)'(NUM_PORTS);

    logic [PW:0]   sum_v;
    logic [PW-1:0] idx_v;

    // Scan from the farthest offset down so the nearest valid port wins.
    always_comb begin
        winner    = '0;
        any_valid = |valid;
        sum_v     = '0;
        idx_v     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            sum_v = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum_v >= NP_W) begin
                idx_v = PW'(sum_v - NP_W);
            end else begin
                idx_v = sum_v[PW-1:0];
            end
            if (valid[idx_v]) begin
                winner = idx_v;
            end else begin
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/rmt_ingress_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXIS sources into one stream.
// Optional per-port completed-packet counters are enabled by RMT_ARB_STATS_EN.
module rmt_ingress_arbiter
    import rmt_ingress_arbiter_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4
) (
    input  logic                                       clk,
    input  logic                                       aresetn,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                       s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                       s_axis_tlast,
    output logic [NUM_PORTS-1:0]                       s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
    output logic                                       m_axis_tvalid,
    output logic                                       m_axis_tlast,
    input  logic                                       m_axis_tready
`ifdef RMT_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*STATS_CNT_W-1:0]           pkt_cnt
`endif
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int PW = port_idx_w(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        grant_q, grant_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

    logic [DW-1:0]        tdata_a [NUM_PORTS];
    logic [KW-1:0]        tkeep_a [NUM_PORTS];
    logic [UW-1:0]        tuser_a [NUM_PORTS];

    logic [NUM_PORTS-1:0] sel_valid_s;
    logic [PW-1:0]        sel_ptr_s;
    logic [PW-1:0]        winner_s;
    logic                 any_valid_s;
    logic                 busy_s;
    logic                 last_hs_s;
    logic [PW-1:0]        next_ptr_s;
    logic [NUM_PORTS-1:0] grant_oh_s;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign tdata_a[i] = s_axis_tdata[i*DW +: DW];
        assign tkeep_a[i] = s_axis_tkeep[i*KW +: KW];
        assign tuser_a[i] = s_axis_tuser[i*UW +: UW];
    end

    rmt_ingress_arbiter_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_rr_select (
        .valid     (sel_valid_s),
        .rr_ptr    (sel_ptr_s),
        .winner    (winner_s),
        .any_valid (any_valid_s)
    );

    // Grant decode, closing-beat detect and the pointer that follows the grant.
    always_comb begin
        busy_s     = aresetn && (state_q == ST_BUSY);
        last_hs_s  = busy_s && s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q];
        grant_oh_s = NUM_PORTS'(1) << grant_q;
        if (grant_q == PW'(NUM_PORTS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_q + PW'(1);
        end
    end

    // Arbitration inputs; on a closing beat the finishing port's own tvalid
    // belongs to the beat being consumed, so it does not bid for the next slot.
    always_comb begin
        sel_valid_s = s_axis_tvalid;
        sel_ptr_s   = rr_ptr_q;
        if (last_hs_s) begin
            sel_valid_s = s_axis_tvalid & ~grant_oh_s;
            sel_ptr_s   = next_ptr_s;
        end else begin
            sel_valid_s = s_axis_tvalid;
            sel_ptr_s   = rr_ptr_q;
        end
    end

    // Next-state logic for the IDLE/BUSY grant FSM.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_d = ST_BUSY;
                    grant_d = winner_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_hs_s) begin
                    rr_ptr_d = next_ptr_s;
                    if (any_valid_s) begin
                        state_d = ST_BUSY;
                        grant_d = winner_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output mux: gated by aresetn so everything reads 0 while reset is held.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (busy_s) begin
            m_axis_tdata           = tdata_a[grant_q];
            m_axis_tkeep           = tkeep_a[grant_q];
            m_axis_tuser           = tuser_a[grant_q];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tlast           = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end else begin
            s_axis_tready = '0;
        end
    end

`ifdef RMT_ARB_STATS_EN
    logic [STATS_CNT_W-1:0] pkt_cnt_q [NUM_PORTS];
    logic [STATS_CNT_W-1:0] pkt_cnt_d [NUM_PORTS];

    // Count closing handshakes per granted port; wraps naturally at 2^32.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if (last_hs_s && (grant_q == PW'(i))) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + STATS_CNT_W'(1);
            end else begin
                pkt_cnt_d[i] = pkt_cnt_q[i];
            end
        end
    end

    // Packet counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!aresetn) begin
                pkt_cnt_q[i] <= '0;
            end else begin
                pkt_cnt_q[i] <= pkt_cnt_d[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_pkt_cnt
        assign pkt_cnt[i*STATS_CNT_W +: STATS_CNT_W] = pkt_cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Self-checking bench for rmt_ingress_arbiter: per-port beat queues as sources,
// a port-level ownership model, and directed plus randomized scenarios.
module tb_rmt_ingress_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic              clk;
    logic              aresetn;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N*UW-1:0]   s_axis_tuser;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tlast;
    logic [N-1:0]      s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
`ifdef RMT_ARB_STATS_EN
    logic [N*32-1:0]   pkt_cnt;
`endif

    rmt_ingress_arbiter #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .NUM_PORTS            (N)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
`ifdef RMT_ARB_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    beat_t       src_q [N][$];
    bit          hold [N];
    int          starts [$];
    int          cur_m;
    int          ptr_m;
    bit          in_pkt [N];
    int unsigned cnt_m [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First set bit of v at or after start, cyclically; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int p = 0; p < N; p++) if (src_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_pkt(input int p, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = DW'($urandom);
            b.keep = KW'($urandom);
            b.user = UW'($urandom);
            b.last = (k == len - 1);
            src_q[p].push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int p = 0; p < N; p++) begin
            if (!hold[p] && src_q[p].size() != 0) begin
                b = src_q[p][0];
                s_axis_tdata[p*DW +: DW] = b.data;
                s_axis_tkeep[p*KW +: KW] = b.keep;
                s_axis_tuser[p*UW +: UW] = b.user;
                s_axis_tvalid[p]         = 1'b1;
                s_axis_tlast[p]          = b.last;
            end else begin
                s_axis_tdata[p*DW +: DW] = '0;
                s_axis_tkeep[p*KW +: KW] = '0;
                s_axis_tuser[p*UW +: UW] = '0;
                s_axis_tvalid[p]         = 1'b0;
                s_axis_tlast[p]          = 1'b0;
            end
        end
    endtask

    // One clock: drive, check at the falling edge, advance the model.
    task automatic cycle();
        logic [N-1:0] tv;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] msk;
        beat_t        b;
        int           acc;
        drive();
        @(negedge clk);
        tv = s_axis_tvalid;
        if (!aresetn) begin
            chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
            chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
            chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
            cur_m = -1;
            ptr_m = 0;
            for (int p = 0; p < N; p++) begin
                in_pkt[p] = 1'b0;
                cnt_m[p]  = 0;
            end
        end else begin
`ifdef RMT_ARB_STATS_EN
            for (int p = 0; p < N; p++) chk("pkt_cnt", 64'(pkt_cnt[p*32 +: 32]), 64'(cnt_m[p]));
`endif
            exp_rdy = '0;
            if (cur_m >= 0) exp_rdy[cur_m] = m_axis_tready;
            chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
            chk("m_tvalid", 64'(m_axis_tvalid), (cur_m >= 0) ? 64'(tv[cur_m]) : 64'd0);
            if (cur_m >= 0 && tv[cur_m]) begin
                b = src_q[cur_m][0];
                chk("m_tdata", 64'(m_axis_tdata), 64'(b.data));
                chk("m_tkeep", 64'(m_axis_tkeep), 64'(b.keep));
                chk("m_tuser", 64'(m_axis_tuser), 64'(b.user));
                chk("m_tlast", 64'(m_axis_tlast), 64'(b.last));
                if (m_axis_tready) begin
                    acc = cur_m;
                    void'(src_q[acc].pop_front());
                    if (!in_pkt[acc]) starts.push_back(acc);
                    in_pkt[acc] = !b.last;
                    if (b.last) begin
                        cnt_m[acc]++;
                        ptr_m = (acc + 1) % N;
                        msk = '0;
                        msk[acc] = 1'b1;
                        cur_m = pick(tv & ~msk, ptr_m);
                    end
                end
            end else if (cur_m < 0 && tv != '0) begin
                cur_m = pick(tv, ptr_m);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        m_axis_tready = 1'b1;
        for (int p = 0; p < N; p++) begin
            src_q[p].delete();
            hold[p] = 1'b0;
        end
        cycle();
        cycle();
        aresetn = 1'b1;
        starts.delete();
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (!all_empty() && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_done", 64'(all_empty()), 64'd1);
    endtask

    int n;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        aresetn       = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        cur_m         = -1;
        ptr_m         = 0;
        for (int p = 0; p < N; p++) begin
            hold[p]   = 1'b0;
            in_pkt[p] = 1'b0;
            cnt_m[p]  = 0;
        end
        @(posedge clk);
        #1;

        // Only port 2 sends a 3-beat packet from reset.
        do_reset();
        add_pkt(2, 3);
        drain(50, n);
        chk("p2_cycles", 64'(n), 64'd4);
        chk("p2_nstarts", 64'(starts.size()), 64'd1);
        if (starts.size() > 0) chk("p2_grant", 64'(starts[0]), 64'd2);

        // All four ports back to back: 0,1,2,3,0 with no idle cycle.
        do_reset();
        for (int p = 0; p < N; p++) add_pkt(p, 2);
        add_pkt(0, 2);
        drain(100, n);
        chk("b2b_cycles", 64'(n), 64'd11);
        chk("b2b_nstarts", 64'(starts.size()), 64'd5);
        for (int i = 0; i < 5 && i < starts.size(); i++) chk("b2b_order", 64'(starts[i]), 64'(exp_order[i]));

        // Downstream ready toggles during a 4-beat packet from port 1.
        do_reset();
        add_pkt(1, 4);
        n = 0;
        while (!all_empty() && n < 50) begin
            cycle();
            m_axis_tready = ~m_axis_tready;
            n++;
        end
        chk("toggle_done", 64'(all_empty()), 64'd1);
        chk("toggle_grant", (starts.size() > 0) ? 64'(starts[0]) : 64'hFFFF, 64'd1);
        m_axis_tready = 1'b1;

        // Port 0 pauses 5 cycles mid-packet while port 3 waits.
        do_reset();
        add_pkt(0, 4);
        add_pkt(3, 2);
        n = 0;
        while (src_q[0].size() > 2 && n < 20) begin
            cycle();
            n++;
        end
        hold[0] = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("p3_waiting", 64'(src_q[3].size()), 64'd2);
        hold[0] = 1'b0;
        drain(50, n);
        chk("stall_nstarts", 64'(starts.size()), 64'd2);
        if (starts.size() == 2) begin
            chk("stall_first", 64'(starts[0]), 64'd0);
            chk("stall_second", 64'(starts[1]), 64'd3);
        end

        // Reset on beat 2 of a port-3 packet, then ports 1 and 3 valid.
        do_reset();
        add_pkt(3, 4);
        n = 0;
        while (src_q[3].size() > 3 && n < 20) begin
            cycle();
            n++;
        end
        aresetn = 1'b0;
        cycle();
        for (int p = 0; p < N; p++) src_q[p].delete();
        add_pkt(1, 2);
        add_pkt(3, 2);
        cycle();
        aresetn = 1'b1;
        starts.delete();
        drain(50, n);
        chk("rst_nstarts", 64'(starts.size()), 64'd2);
        if (starts.size() == 2) begin
            chk("rst_first", 64'(starts[0]), 64'd1);
            chk("rst_second", 64'(starts[1]), 64'd3);
        end

        // Randomized traffic with random source pauses and downstream ready.
        do_reset();
        for (int i = 0; i < 40; i++) add_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)));
        n = 0;
        while (!all_empty() && n < 3000) begin
            for (int p = 0; p < N; p++) hold[p] = ($urandom_range(0, 3) == 0);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        chk("rand_done", 64'(all_empty()), 64'd1);
        for (int p = 0; p < N; p++) hold[p] = 1'b0;
        m_axis_tready = 1'b1;

`ifdef RMT_ARB_STATS_EN
        // Five packets from port 0, two from port 3.
        do_reset();
        for (int i = 0; i < 5; i++) add_pkt(0, int'($urandom_range(1, 3)));
        for (int i = 0; i < 2; i++) add_pkt(3, int'($urandom_range(1, 3)));
        drain(200, n);
        cycle();
        chk("stats_p0", 64'(pkt_cnt[0*32 +: 32]), 64'd5);
        chk("stats_p1", 64'(pkt_cnt[1*32 +: 32]), 64'd0);
        chk("stats_p2", 64'(pkt_cnt[2*32 +: 32]), 64'd0);
        chk("stats_p3", 64'(pkt_cnt[3*32 +: 32]), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
